// File: rtl/dlx_hazard_unit.sv
// dlx_hazard_unit -- hazard controller for the DLX 5-stage pipeline.
//
// Tracks in-flight destination registers in a tag pipeline mirroring EX..WB.
// From it, the unit derives load-use stalls, EX operand forwarding selects
// and IF/ID flush bubbles after taken branches. It also keeps saturating
// statistics counters.
//
// Build option: define DLX_HAZ_FORWARD_EN to enable operand forwarding.
// When it is undefined, every RAW hazard on slots 0..DEPTH-2 stalls decode,
// and both forwarding selects read 0.
//
// Ports:
//   clock        pipeline clock, rising edge
//   reset        asynchronous active-low reset
//   id_*         decode-stage instruction fields
//   branch_en    taken branch resolved in EX this cycle
//   stall_if     hold PC and IF/ID
//   bubble_ex    load NOP into ID/EX
//   flush_if_id  replace IF/ID with NOP
//   fwd_a_sel    operand A source (0 = regfile, k = slot k-1 result)
//   fwd_b_sel    operand B source
//   stall_count  saturating count of stall cycles
//   flush_count  saturating count of flush cycles
module dlx_hazard_unit #(
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_write,
  input  logic                  id_is_load,
  input  logic                  branch_en,
  output logic                  stall_if,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic [2:0]            fwd_a_sel,
  output logic [2:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  // The WB slot is never consulted, so only slots 0..DEPTH-2 are stored.
  // The load flag only matters while the producer sits in EX (slot 0).
  localparam int unsigned TRACK = DEPTH - 1;

  logic [TRACK-1:0]      slot_valid;
  logic [REG_ADDR_W-1:0] slot_rd [TRACK];
  logic                  slot0_load;
  logic [2:0]            flush_cnt;

  logic [TRACK-1:0] match_a;
  logic [TRACK-1:0] match_b;
  logic             flush_active;
  logic             hazard;
  logic             stall;
  logic             bubble;
  logic [2:0]       sel_a;
  logic [2:0]       sel_b;

  always_comb begin
    for (int unsigned k = 0; k < TRACK; k++) begin
      match_a[k] = id_valid && id_rs1_used && (id_rs1 != '0) &&
                   slot_valid[k] && (slot_rd[k] == id_rs1);
      match_b[k] = id_valid && id_rs2_used && (id_rs2 != '0) &&
                   slot_valid[k] && (slot_rd[k] == id_rs2);
    end
  end

  // Outputs are gated by reset so they read 0 while reset is held.
  assign flush_active = reset && (branch_en || (flush_cnt != '0));

`ifdef DLX_HAZ_FORWARD_EN
  assign hazard = (match_a[0] || match_b[0]) && slot0_load;
`else
  // Any in-flight producer stalls; the load-use term is implied by it.
  assign hazard = ((match_a[0] || match_b[0]) && slot0_load) ||
                  (|(match_a | match_b));
`endif

  assign stall  = reset && hazard && !flush_active;
  assign bubble = stall || flush_active;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
`ifdef DLX_HAZ_FORWARD_EN
    // Walk oldest to youngest so the youngest matching slot wins.
    for (int unsigned i = 0; i < TRACK; i++) begin
      if (match_a[TRACK-1-i]) sel_a = 3'(TRACK - i);
      if (match_b[TRACK-1-i]) sel_b = 3'(TRACK - i);
    end
`endif
    if (stall || !reset) begin
      sel_a = '0;
      sel_b = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid  <= '0;
      for (int unsigned k = 0; k < TRACK; k++) slot_rd[k] <= '0;
      slot0_load  <= 1'b0;
      flush_cnt   <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (bubble) begin
        slot_valid[0] <= 1'b0;
        slot_rd[0]    <= '0;
        slot0_load    <= 1'b0;
      end else begin
        slot_valid[0] <= id_valid && id_rd_write && (id_rd != '0);
        slot_rd[0]    <= id_rd;
        slot0_load    <= id_is_load;
      end
      for (int unsigned k = 1; k < TRACK; k++) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_rd[k]    <= slot_rd[k-1];
      end

      if (branch_en)              flush_cnt <= 3'(FLUSH_CYCLES);
      else if (flush_cnt != '0)   flush_cnt <= flush_cnt - 3'd1;

      if (stall && (stall_count != '1))        stall_count <= stall_count + 1'b1;
      if (flush_active && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

  assign stall_if    = stall;
  assign bubble_ex   = bubble;
  assign flush_if_id = flush_active;
  assign fwd_a_sel   = sel_a;
  assign fwd_b_sel   = sel_b;

endmodule
